// File: rtl/avg_pkg.sv
// Shared types and default dimensions for the lag-pair averaging frame controller.
package avg_pkg;

  localparam int DEF_FRAME_LEN = 128;
  localparam int DEF_LAG       = 8;
  localparam int DEF_DW        = 8;
  localparam int DEF_IDX_W     = $clog2(DEF_FRAME_LEN);
  localparam int DEF_OUT_CNT   = DEF_FRAME_LEN - DEF_LAG;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/pair_avg.sv
// Combinational mean of two samples. Define AVG_ROUND_EN for round-half-up;
// otherwise the result is truncated.
module pair_avg #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result
);

  logic [DW:0] sum;

  // One extra bit holds the carry, so the sum never overflows.
  assign sum = {1'b0, a} + {1'b0, b};

`ifdef AVG_ROUND_EN
  // sum[0] is only set when sum[DW:1] is below its maximum, so this cannot wrap.
  assign result = sum[DW:1] + DW'(sum[0]);
`else
  assign result = sum[DW:1];
`endif

endmodule

// File: rtl/avg_frame_ctrl.sv
// Frame controller: fills a FRAME_LEN buffer from a valid/ready stream, then drains
// FRAME_LEN-LAG pair averages through a registered output stage. Rounding via AVG_ROUND_EN.
module avg_frame_ctrl
  import avg_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int LAG       = DEF_LAG,
  parameter int DW        = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          frame_done
);

  localparam int IDX_W   = $clog2(FRAME_LEN);
  localparam int OUT_CNT = FRAME_LEN - LAG;

  localparam logic [IDX_W-1:0] LAST_WR = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] RD_END  = IDX_W'(OUT_CNT);
  localparam logic [IDX_W-1:0] LAG_IDX = IDX_W'(LAG);

  state_t state;
  state_t next_state;

  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] pair_idx;
  logic [DW-1:0]    frame_buf [FRAME_LEN];
  logic [DW-1:0]    avg_res;

  logic accept;
  logic last_accept;
  logic consume;
  logic load;
  logic last_consume;

  // Decoded from state rather than in_ready to keep the handshake free of comb loops.
  assign accept       = in_valid && (state == FILL);
  assign last_accept  = accept && (wr_idx == LAST_WR);
  assign consume      = out_valid && out_ready;
  assign load         = (state == DRAIN) && (rd_idx != RD_END) && (!out_valid || out_ready);
  assign last_consume = (state == DRAIN) && consume && (rd_idx == RD_END);

  // Power-of-two frame length makes the modular wrap harmless once rd_idx reaches RD_END.
  assign pair_idx = rd_idx + LAG_IDX;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FILL;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    next_state = state;
    in_ready   = 1'b0;
    unique case (state)
      FILL: begin
        in_ready = 1'b1;
        if (last_accept) next_state = DRAIN;
      end
      DRAIN: begin
        if (last_consume) next_state = FILL;
      end
      default: next_state = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx <= '0;
    end else if (accept) begin
      wr_idx <= wr_idx + 1'b1;
    end
  end

  // NOTE: the frame buffer has no reset; every entry read in a frame was written earlier in it.
  always_ff @(posedge clk) begin
    if (accept) begin
      frame_buf[wr_idx] <= in_data;
    end
  end

  pair_avg #(
    .DW(DW)
  ) u_pair_avg (
    .a      (frame_buf[rd_idx]),
    .b      (frame_buf[pair_idx]),
    .result (avg_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out        <= '0;
      out_valid  <= 1'b0;
      rd_idx     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_consume;
      if (load) begin
        out       <= avg_res;
        out_valid <= 1'b1;
        rd_idx    <= rd_idx + 1'b1;
      end else if (consume) begin
        out_valid <= 1'b0;
        if (last_consume) rd_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_avg_frame_ctrl.sv
// Directed self-checking bench for avg_frame_ctrl (default 128/8/8 configuration).
module tb_avg_frame_ctrl;
  import avg_pkg::*;

  localparam int FL   = DEF_FRAME_LEN;
  localparam int LG   = DEF_LAG;
  localparam int NOUT = FL - LG;

  typedef logic [7:0] frame_t [FL];
  typedef logic [7:0] res_q_t [$];

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       frame_done;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  avg_frame_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out        (out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done)
  );

  function automatic int first_mismatch(input res_q_t r, input res_q_t e);
    for (int j = 0; j < e.size(); j++)
      if (j >= r.size() || r[j] !== e[j]) return j;
    return -1;
  endfunction

  // Sends one frame; gap_pct is the chance per cycle of holding in_valid low.
  task automatic feed(input frame_t d, input int gap_pct);
    int i = 0;
    int budget = 0;
    while (i < FL && budget < 4000) begin
      @(negedge clk);
      budget++;
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 8'h00;
      end else begin
        in_valid = 1'b1;
        in_data  = d[i];
      end
      if (in_valid && in_ready) i++;
    end
    if (i < FL) begin
      tests_run++;
      tests_failed++;
      $display("FAIL feed_timeout: accepted %0d samples, required %0d", i, FL);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Collects results until frame_done or max_res results; junk drives in_valid during drain.
  task automatic collect(input int ready_pct, input int max_res, input bit junk,
                         output res_q_t res, output int cycles, output int stall_viol,
                         output int ready_viol);
    logic [7:0] prev_out = 8'h00;
    bit prev_stall = 1'b0;
    bit done = 1'b0;
    res = {};
    cycles = 0;
    stall_viol = 0;
    ready_viol = 0;
    while (!done && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (prev_stall && (!out_valid || out !== prev_out)) stall_viol++;
      if (frame_done) begin
        done      = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end else begin
        if (in_ready) ready_viol++;
        in_valid  = junk;
        in_data   = 8'hA5;
        out_ready = ($urandom_range(99) < ready_pct);
        if (out_valid && out_ready) begin
          res.push_back(out);
          if (res.size() == max_res) done = 1'b1;
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = out;
      end
    end
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL collect_timeout: got %0d results after %0d cycles", res.size(), cycles);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (out !== 8'h00) begin tests_failed++; $display("FAIL reset_out: got %0d expected 0", out); end
    tests_run++;
    if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ramp;
    frame_t d;
    res_q_t res, exp;
    int cycles, sv, rv, mm;
    for (int i = 0; i < FL; i++) d[i] = 8'(i);
    for (int j = 0; j < NOUT; j++) exp.push_back(8'(j + 4));
    out_ready = 1'b1;
    feed(d, 0);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL ramp_after_last_sample: out_valid=%b in_ready=%b expected 0 0", out_valid, in_ready);
    end
    collect(100, 1000, 1'b0, res, cycles, sv, rv);
    tests_run++;
    if (cycles !== NOUT + 1) begin tests_failed++; $display("FAIL ramp_latency: frame_done after %0d cycles expected %0d", cycles, NOUT + 1); end
    tests_run++;
    if (res.size() !== NOUT) begin tests_failed++; $display("FAIL ramp_count: got %0d expected %0d", res.size(), NOUT); end
    mm = first_mismatch(res, exp);
    tests_run++;
    if (mm != -1) begin tests_failed++; $display("FAIL ramp_data[%0d]: got %0d expected %0d", mm, (mm < res.size()) ? res[mm] : 8'h00, exp[mm]); end
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ramp_done_state: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL ramp_done_pulse: got %b expected 0", frame_done); end
  endtask

  task automatic test_rounding;
    frame_t d;
    res_q_t res, exp;
    int cycles, sv, rv, mm;
`ifdef AVG_ROUND_EN
    logic [7:0] lo = 8'd2;
`else
    logic [7:0] lo = 8'd1;
`endif
    for (int i = 0; i < FL; i++) d[i] = (i < LG) ? 8'd1 : 8'd2;
    for (int j = 0; j < NOUT; j++) exp.push_back((j < LG) ? lo : 8'd2);
    feed(d, 0);
    collect(100, 1000, 1'b0, res, cycles, sv, rv);
    mm = first_mismatch(res, exp);
    tests_run++;
    if (mm != -1 || res.size() !== NOUT) begin
      tests_failed++;
      $display("FAIL rounding_data[%0d]: got %0d expected %0d (count %0d)", mm, (mm >= 0 && mm < res.size()) ? res[mm] : 8'h00, (mm >= 0) ? exp[mm] : 8'h00, res.size());
    end
  endtask

  task automatic test_backpressure;
    frame_t d;
    res_q_t res, exp;
    int cycles, sv, rv, mm;
    for (int i = 0; i < FL; i++) d[i] = 8'(i);
    for (int j = 0; j < NOUT; j++) exp.push_back(8'(j + 4));
    feed(d, 0);
    collect(30, 1000, 1'b0, res, cycles, sv, rv);
    tests_run++;
    if (sv !== 0) begin tests_failed++; $display("FAIL bp_stall_stable: got %0d violations expected 0", sv); end
    tests_run++;
    if (res.size() !== NOUT) begin tests_failed++; $display("FAIL bp_count: got %0d expected %0d", res.size(), NOUT); end
    mm = first_mismatch(res, exp);
    tests_run++;
    if (mm != -1) begin tests_failed++; $display("FAIL bp_data[%0d]: got %0d expected %0d", mm, (mm < res.size()) ? res[mm] : 8'h00, exp[mm]); end
    @(negedge clk);
    tests_run++;
    if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL bp_done_pulse: got %b expected 0", frame_done); end
  endtask

  task automatic test_full_scale;
    frame_t d;
    res_q_t res, exp;
    int cycles, sv, rv, mm;
    logic [7:0] lvl [2];
    lvl[0] = 8'd255;
    lvl[1] = 8'd0;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp = {};
      for (int i = 0; i < FL; i++) d[i] = lvl[k];
      for (int j = 0; j < NOUT; j++) exp.push_back(lvl[k]);
      feed(d, 0);
      collect(100, 1000, 1'b0, res, cycles, sv, rv);
      mm = first_mismatch(res, exp);
      tests_run++;
      if (mm != -1 || res.size() !== NOUT) begin
        tests_failed++;
        $display("FAIL full_scale_%0d[%0d]: got %0d expected %0d (count %0d)", lvl[k], mm, (mm >= 0 && mm < res.size()) ? res[mm] : 8'h00, lvl[k], res.size());
      end
    end
  endtask

  task automatic test_reset_mid_drain;
    frame_t d;
    res_q_t res, exp;
    int cycles, sv, rv, mm;
    for (int i = 0; i < FL; i++) d[i] = 8'(i);
    for (int j = 0; j < NOUT; j++) exp.push_back(8'(j + 4));
    feed(d, 0);
    collect(100, 50, 1'b0, res, cycles, sv, rv);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset_state: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    reset = 1'b1;
    feed(d, 0);
    collect(100, 1000, 1'b0, res, cycles, sv, rv);
    mm = first_mismatch(res, exp);
    tests_run++;
    if (mm != -1 || res.size() !== NOUT) begin
      tests_failed++;
      $display("FAIL mid_reset_data[%0d]: got %0d expected %0d (count %0d)", mm, (mm >= 0 && mm < res.size()) ? res[mm] : 8'h00, (mm >= 0) ? exp[mm] : 8'h00, res.size());
    end
  endtask

  task automatic test_back_to_back;
    frame_t d;
    res_q_t res, exp;
    int cycles, sv, rv, mm;
    for (int f = 0; f < 2; f++) begin
      exp = {};
      for (int i = 0; i < FL; i++) d[i] = (f == 0) ? 8'(i) : 8'(200 - i);
      for (int j = 0; j < NOUT; j++) exp.push_back((f == 0) ? 8'(j + 4) : 8'(196 - j));
      feed(d, 30);
      collect(100, 1000, 1'b1, res, cycles, sv, rv);
      tests_run++;
      if (rv !== 0) begin tests_failed++; $display("FAIL b2b_in_ready_drain_%0d: got %0d cycles high expected 0", f, rv); end
      mm = first_mismatch(res, exp);
      tests_run++;
      if (mm != -1 || res.size() !== NOUT) begin
        tests_failed++;
        $display("FAIL b2b_data_%0d[%0d]: got %0d expected %0d (count %0d)", f, mm, (mm >= 0 && mm < res.size()) ? res[mm] : 8'h00, (mm >= 0) ? exp[mm] : 8'h00, res.size());
      end
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_after_done_%0d: got %b expected 1", f, in_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_rounding();
    test_backpressure();
    test_full_scale();
    test_reset_mid_drain();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
